// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_t;

    function automatic logic is_div(md_op_t op);
        return op[2];
    endfunction

    function automatic logic is_rem(md_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

    function automatic logic is_signed_a(md_op_t op);
        return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_signed_b(md_op_t op);
        return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement; used for operand magnitudes and final result sign.
module muldiv_negate #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic         neg_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        y_o = neg_i ? -a_i : a_i;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit: shift-add multiply, restoring divide,
// one step per cycle with valid/ready handshakes on both sides.
import muldiv_pkg::*;

module muldiv_unit #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] SrcA,
    input  logic [DWIDTH-1:0] SrcB,
    input  logic [2:0]        MDOp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] MDResult,
    output logic              Z
);

    localparam int unsigned CNTW = $clog2(DWIDTH) + 1;
    localparam logic [CNTW-1:0]   CntFull = CNTW'(DWIDTH);
    localparam logic [CNTW-1:0]   CntOne  = CNTW'(1);
    localparam logic [DWIDTH-1:0] MinNeg  = {1'b1, {(DWIDTH-1){1'b0}}};

    md_state_t               state_q, state_d;
    md_op_t                  op_q, op_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic [DWIDTH-1:0]       opnd_q, opnd_d;
    logic [2*DWIDTH-1:0]     acc_q, acc_d;
    logic [DWIDTH:0]         rem_q, rem_d;
    logic                    sa_q, sa_d;
    logic                    sb_q, sb_d;
    logic [DWIDTH-1:0]       res_q, res_d;

    md_op_t                  in_op;
    logic                    in_sa, in_sb;
    logic [DWIDTH-1:0]       mag_a, mag_b;
    logic                    div_zero, div_ovf;
    logic [DWIDTH-1:0]       fast_res;

    logic [DWIDTH:0]         mul_sum;
    logic [2*DWIDTH-1:0]     mul_acc;
    logic [DWIDTH+1:0]       div_shift;
    logic                    div_ge;
    logic [DWIDTH:0]         div_diff, div_rem;
    logic [2*DWIDTH-1:0]     div_acc;

    logic [2*DWIDTH-1:0]     raw_res, signed_res;
    logic                    res_neg;
    logic [DWIDTH-1:0]       final_res;

    always_comb begin
        in_op    = md_op_t'(MDOp);
        in_sa    = SrcA[DWIDTH-1] & is_signed_a(in_op);
        in_sb    = SrcB[DWIDTH-1] & is_signed_b(in_op);
        div_zero = is_div(in_op) && (SrcB == '0);
        div_ovf  = ((in_op == DIV) || (in_op == REM)) && (SrcA == MinNeg) && (SrcB == '1);
        if (div_zero) begin
            fast_res = is_rem(in_op) ? SrcA : '1;
        end else begin
            fast_res = is_rem(in_op) ? '0 : SrcA;
        end
    end

    // Magnitudes are unsigned DWIDTH so the most-negative operand stays representable.
    muldiv_negate #(.W(DWIDTH)) u_mag_a (
        .a_i   (SrcA),
        .neg_i (in_sa),
        .y_o   (mag_a)
    );

    muldiv_negate #(.W(DWIDTH)) u_mag_b (
        .a_i   (SrcB),
        .neg_i (in_sb),
        .y_o   (mag_b)
    );

    // One iteration of each algorithm; op_q picks which one advances the state.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]};
        if (acc_q[0]) begin
            mul_sum = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + {1'b0, opnd_q};
        end
        mul_acc = {mul_sum, acc_q[DWIDTH-1:1]};

        div_shift = {rem_q, acc_q[DWIDTH-1]};
        div_ge    = div_shift >= {2'b00, opnd_q};
        div_diff  = div_shift[DWIDTH:0] - {1'b0, opnd_q};
        div_rem   = div_ge ? div_diff : div_shift[DWIDTH:0];
        div_acc   = {acc_q[2*DWIDTH-1:DWIDTH], acc_q[DWIDTH-2:0], div_ge};
    end

    always_comb begin
        if (is_div(op_q)) begin
            raw_res = {{DWIDTH{1'b0}}, is_rem(op_q) ? div_rem[DWIDTH-1:0] : div_acc[DWIDTH-1:0]};
            res_neg = is_rem(op_q) ? sa_q : (sa_q ^ sb_q);
        end else begin
            raw_res = mul_acc;
            res_neg = sa_q ^ sb_q;
        end
    end

    muldiv_negate #(.W(2*DWIDTH)) u_res_sign (
        .a_i   (raw_res),
        .neg_i (res_neg),
        .y_o   (signed_res)
    );

    always_comb begin
        if ((op_q == MUL) || is_div(op_q)) begin
            final_res = signed_res[DWIDTH-1:0];
        end else begin
            final_res = signed_res[2*DWIDTH-1:DWIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d   = in_op;
                    sa_d   = in_sa;
                    sb_d   = in_sb;
                    opnd_d = is_div(in_op) ? mag_b : mag_a;
                    acc_d  = {{DWIDTH{1'b0}}, is_div(in_op) ? mag_a : mag_b};
                    rem_d  = '0;
                    if (div_zero || div_ovf) begin
                        res_d   = fast_res;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CntFull;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = is_div(op_q) ? div_acc : mul_acc;
                rem_d = is_div(op_q) ? div_rem : rem_q;
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    res_d   = final_res;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= MUL;
            cnt_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign MDResult  = res_q;
    assign Z         = (res_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed table-driven bench for muldiv_unit plus back-pressure and mid-op reset sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [2:0]  MDOp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] MDResult;
    logic        Z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.DWIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .MDOp      (MDOp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .MDResult  (MDResult),
        .Z         (Z)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        fast;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Accept one op, return result, Z and latency counted in edges including the accept edge.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z, output int lat);
        int guard;
        @(negedge clk);
        MDOp     = op;
        SrcA     = a;
        SrcB     = b;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = MDResult;
        z   = Z;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic        z;
        logic [31:0] held;
        int          lat;
        int          guard;

        vecs[0]  = '{"mul_7x-3",      3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{"mulh_min_sq",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
        vecs[2]  = '{"mulhu_ones",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[3]  = '{"mulhsu_m1x2",   3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{"divu_100_7",    3'd5, 32'd100,      32'd7,        32'd14,       1'b0};
        vecs[5]  = '{"remu_100_7",    3'd7, 32'd100,      32'd7,        32'd2,        1'b0};
        vecs[6]  = '{"div_m100_7",    3'd4, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0};
        vecs[7]  = '{"rem_m100_7",    3'd6, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 1'b0};
        vecs[8]  = '{"div_5_0",       3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{"rem_5_0",       3'd6, 32'd5,        32'd0,        32'd5,        1'b1};
        vecs[10] = '{"div_ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[11] = '{"rem_ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1};
        vecs[12] = '{"mul_min_x_m1",  3'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        vecs[13] = '{"mulh_min_x_m1", 3'd1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0};
        vecs[14] = '{"divu_7_0",      3'd5, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[15] = '{"remu_x_0",      3'd7, 32'h12345678, 32'd0,        32'h12345678, 1'b1};
        vecs[16] = '{"div_7_m2",      3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
        vecs[17] = '{"rem_7_m2",      3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        SrcA      = '0;
        SrcB      = '0;
        MDOp      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    MDResult,       32'd0);
        check("rst_z",         32'(Z),         32'd1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat);
            check({vecs[i].name, "_res"}, res, vecs[i].exp);
            check({vecs[i].name, "_z"}, 32'(z), 32'(vecs[i].exp == 32'd0));
            check({vecs[i].name, "_lat"}, 32'(lat), vecs[i].fast ? 32'd1 : 32'd33);
            check({vecs[i].name, "_ready_after"}, 32'(in_ready), 32'd1);
        end

        // Back-pressure, with a second request raised during CALC that must be ignored.
        @(negedge clk);
        MDOp     = 3'd5;
        SrcA     = 32'd1000;
        SrcB     = 32'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        MDOp     = 3'd0;
        SrcA     = 32'd3;
        SrcB     = 32'd4;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("calc_in_ready_low", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("bp_result", MDResult, 32'd111);
        held = MDResult;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_result_held", MDResult, held);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        check("bp_valid_dropped", 32'(out_valid), 32'd0);
        check("bp_result_kept", MDResult, 32'd111);

        // Reset at iteration 10 of a multiply aborts it.
        @(negedge clk);
        MDOp     = 3'd0;
        SrcA     = 32'd5;
        SrcB     = 32'd6;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", MDResult, 32'd0);
        check("mid_rst_z", 32'(Z), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            check("mid_rst_no_result", 32'(out_valid), 32'd0);
        end
        do_op(3'd0, 32'd3, 32'd4, res, z, lat);
        check("post_rst_mul", res, 32'd12);
        check("post_rst_lat", 32'(lat), 32'd33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
